// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter; no logic, no latency.
package dmem_arb_pkg;

  localparam int DEF_AW           = 8;
  localparam int DEF_DW           = 8;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int STAT_W           = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    CORE   = 2'd1,
    LOADER = 2'd2
  } req_tag_e;

endpackage

// File: rtl/dmem_arb_stats.sv
// Saturating activity counters (core stall cycles, loader beats); one-cycle update latency.
module dmem_arb_stats
  import dmem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              c_stall,
  input  logic              l_beat,
  output logic [STAT_W-1:0] stat_cstall,
  output logic [STAT_W-1:0] stat_lbeats
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_cstall <= '0;
      stat_lbeats <= '0;
    end else begin
      if (c_stall && (stat_cstall != '1)) stat_cstall <= stat_cstall + STAT_W'(1);
      if (l_beat  && (stat_lbeats != '1)) stat_lbeats <= stat_lbeats + STAT_W'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port dmem arbiter: combinational grant, read data one cycle after grant; loader bursts
// yield one core beat every STARVE_LIMIT beats. DMEM_ARB_STATS_EN adds STAT_CSTALL/STAT_LBEATS.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW           = DEF_AW,
  parameter int DW           = DEF_DW,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              C_REQ,
  input  logic              C_WE,
  input  logic [AW-1:0]     C_ADDR,
  input  logic [DW-1:0]     C_WDATA,
  output logic              C_GNT,
  output logic              C_RVALID,
  output logic [DW-1:0]     C_RDATA,
  input  logic              L_REQ,
  input  logic              L_WE,
  input  logic [AW-1:0]     L_ADDR,
  input  logic [4:0]        L_LEN,
  input  logic [DW-1:0]     L_WDATA,
  output logic              L_GNT,
  output logic              L_RVALID,
  output logic [DW-1:0]     L_RDATA,
  output logic              L_DONE,
  output logic              M_EN,
  output logic              M_WE,
  output logic [AW-1:0]     M_ADDR,
  output logic [DW-1:0]     M_WDATA,
`ifdef DMEM_ARB_STATS_EN
  output logic [STAT_W-1:0] STAT_CSTALL,
  output logic [STAT_W-1:0] STAT_LBEATS,
`endif
  input  logic [DW-1:0]     M_RDATA
);

  localparam int SCW = $clog2(STARVE_LIMIT + 1);

  arb_state_e    state;
  req_tag_e      rd_tag;
  logic [AW-1:0] b_addr;
  logic [4:0]    b_rem;
  logic          b_we;
  logic [SCW-1:0] starve_cnt;
  logic          l_done_q;
  logic          c_gnt;
  logic          l_gnt;
  logic          force_core;

  // Core always wins in IDLE; inside a burst it only gets a slot once starved.
  always_comb begin
    force_core = (state == BURST) && C_REQ && (starve_cnt == SCW'(STARVE_LIMIT));
    c_gnt      = 1'b0;
    l_gnt      = 1'b0;
    if (!RESET) begin
      if (state == IDLE) c_gnt = C_REQ;
      else if (force_core) c_gnt = 1'b1;
      else l_gnt = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      rd_tag     <= NONE;
      b_addr     <= '0;
      b_rem      <= '0;
      b_we       <= 1'b0;
      starve_cnt <= '0;
      l_done_q   <= 1'b0;
    end else begin
      l_done_q <= 1'b0;

      if (c_gnt && !C_WE)     rd_tag <= CORE;
      else if (l_gnt && !b_we) rd_tag <= LOADER;
      else                     rd_tag <= NONE;

      if (c_gnt || !C_REQ) starve_cnt <= '0;
      else if (l_gnt)      starve_cnt <= starve_cnt + SCW'(1);

      case (state)
        IDLE: begin
          if (L_REQ) begin
            b_addr <= L_ADDR;
            b_rem  <= L_LEN;
            b_we   <= L_WE;
            state  <= BURST;
          end
        end
        BURST: begin
          if (l_gnt) begin
            b_addr <= b_addr + AW'(1);
            b_rem  <= b_rem - 5'd1;
            if (b_rem == 5'd0) begin
              state    <= IDLE;
              l_done_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign C_GNT    = c_gnt;
  assign L_GNT    = l_gnt;
  assign L_DONE   = l_done_q;
  assign C_RVALID = (rd_tag == CORE);
  assign L_RVALID = (rd_tag == LOADER);
  assign C_RDATA  = C_RVALID ? M_RDATA : '0;
  assign L_RDATA  = L_RVALID ? M_RDATA : '0;

  assign M_EN    = c_gnt | l_gnt;
  assign M_WE    = c_gnt ? C_WE    : (l_gnt ? b_we    : 1'b0);
  assign M_ADDR  = c_gnt ? C_ADDR  : (l_gnt ? b_addr  : '0);
  assign M_WDATA = c_gnt ? C_WDATA : (l_gnt ? L_WDATA : '0);

`ifdef DMEM_ARB_STATS_EN
  dmem_arb_stats u_stats (
    .clk         (CLK),
    .rst         (RESET),
    .c_stall     (C_REQ & ~c_gnt),
    .l_beat      (l_gnt),
    .stat_cstall (STAT_CSTALL),
    .stat_lbeats (STAT_LBEATS)
  );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized + directed bench for dmem_arbiter with a transaction-level reference model and scoreboard.
module tb_dmem_arbiter;

  localparam int SL = 4;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       C_REQ = 1'b0, C_WE = 1'b0;
  logic [7:0] C_ADDR = '0, C_WDATA = '0;
  logic       C_GNT, C_RVALID;
  logic [7:0] C_RDATA;
  logic       L_REQ = 1'b0, L_WE = 1'b0;
  logic [7:0] L_ADDR = '0;
  logic [4:0] L_LEN = '0;
  logic [7:0] L_WDATA = '0;
  logic       L_GNT, L_RVALID, L_DONE;
  logic [7:0] L_RDATA;
  logic       M_EN, M_WE;
  logic [7:0] M_ADDR, M_WDATA;
  logic [7:0] M_RDATA = '0;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] STAT_CSTALL, STAT_LBEATS;
`endif

  dmem_arbiter #(.AW(8), .DW(8), .STARVE_LIMIT(SL)) dut (
    .CLK(CLK), .RESET(RESET),
    .C_REQ(C_REQ), .C_WE(C_WE), .C_ADDR(C_ADDR), .C_WDATA(C_WDATA),
    .C_GNT(C_GNT), .C_RVALID(C_RVALID), .C_RDATA(C_RDATA),
    .L_REQ(L_REQ), .L_WE(L_WE), .L_ADDR(L_ADDR), .L_LEN(L_LEN), .L_WDATA(L_WDATA),
    .L_GNT(L_GNT), .L_RVALID(L_RVALID), .L_RDATA(L_RDATA), .L_DONE(L_DONE),
    .M_EN(M_EN), .M_WE(M_WE), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA),
`ifdef DMEM_ARB_STATS_EN
    .STAT_CSTALL(STAT_CSTALL), .STAT_LBEATS(STAT_LBEATS),
`endif
    .M_RDATA(M_RDATA)
  );

  always #5 CLK = ~CLK;

  // Synchronous-read 256x8 data memory.
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  always @(posedge CLK) begin
    if (M_EN) begin
      if (M_WE) mem[M_ADDR] <= M_WDATA;
      else      M_RDATA <= mem[M_ADDR];
    end
  end

  int checks = 0;
  int failures = 0;

  // Reference model: burst bookkeeping and expected read data in issue order.
  bit         bursting = 0;
  int         b_addr = 0, b_left = 0;
  bit         b_we = 0;
  int         run = 0;
  bit         done_exp = 0, c_rd_prev = 0, l_rd_prev = 0;
  bit         last_exp_c = 0, dut_c = 0, dut_l = 0;
  int         m_cstall = 0, m_lbeats = 0;
  logic [7:0] wq[$];
  logic [7:0] c_exp[$];
  logic [7:0] l_exp[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge CLK) begin
    logic [7:0] e;
    #2;
    if (!RESET) begin
      if (C_RVALID) begin
        if (c_exp.size() == 0) chk("c_rdata_extra", 1, 0);
        else begin e = c_exp.pop_front(); chk("c_rdata", int'(C_RDATA), int'(e)); end
      end
      if (L_RVALID) begin
        if (l_exp.size() == 0) chk("l_rdata_extra", 1, 0);
        else begin e = l_exp.pop_front(); chk("l_rdata", int'(L_RDATA), int'(e)); end
      end
    end
  end

  task automatic step(input bit c_req, input bit c_we, input logic [7:0] c_addr,
                      input logic [7:0] c_wdata, input bit l_req, input bit l_we,
                      input logic [7:0] l_addr, input logic [4:0] l_len);
    bit exp_c, exp_l, was_idle;
    @(negedge CLK);
    chk("l_done", L_DONE, done_exp);
    chk("c_rvalid", C_RVALID, c_rd_prev);
    chk("l_rvalid", L_RVALID, l_rd_prev);
    C_REQ = c_req; C_WE = c_we; C_ADDR = c_addr; C_WDATA = c_wdata;
    L_REQ = l_req; L_WE = l_we; L_ADDR = l_addr; L_LEN = l_len;
    L_WDATA = (bursting && b_we && wq.size() > 0) ? wq[0] : 8'($urandom);
    #1;
    was_idle = !bursting;
    exp_c = 1'b0; exp_l = 1'b0;
    if (was_idle) exp_c = c_req;
    else if (c_req && run == SL) exp_c = 1'b1;
    else exp_l = 1'b1;
    chk("c_gnt", C_GNT, exp_c);
    chk("l_gnt", L_GNT, exp_l);
    chk("m_en", M_EN, exp_c | exp_l);
    if (exp_c) chk("m_addr_core", M_ADDR, c_addr);
    if (exp_l) chk("m_addr_burst", M_ADDR, b_addr);
    dut_c = C_GNT; dut_l = L_GNT; last_exp_c = exp_c;

    done_exp = 0; c_rd_prev = 0; l_rd_prev = 0;
    if (c_req && !exp_c && m_cstall < 65535) m_cstall++;
    if (exp_l && m_lbeats < 65535) m_lbeats++;
    if (exp_c) begin
      if (c_we) ref_mem[c_addr] = c_wdata;
      else begin c_exp.push_back(ref_mem[c_addr]); c_rd_prev = 1; end
    end
    if (exp_l) begin
      if (b_we) ref_mem[b_addr] = wq.pop_front();
      else begin l_exp.push_back(ref_mem[b_addr]); l_rd_prev = 1; end
      b_addr = (b_addr + 1) % 256;
      b_left--;
      if (b_left == 0) begin bursting = 0; done_exp = 1; end
    end
    if (exp_c || !c_req) run = 0;
    else if (exp_l) run++;
    if (was_idle && l_req) begin
      bursting = 1; b_addr = l_addr; b_left = l_len + 1; b_we = l_we;
      wq.delete();
      if (l_we) for (int i = 0; i <= l_len; i++) wq.push_back(8'($urandom));
    end
  endtask

  task automatic idle_step();
    step(0, 0, 8'd0, 8'd0, 0, 0, 8'd0, 5'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 45 && bursting; i++) idle_step();
    if (bursting) chk("drain_timeout", 1, 0);
    idle_step();
    idle_step();
  endtask

  task automatic do_reset(input int hold);
    @(negedge CLK);
    RESET = 1'b1; C_REQ = 1'b1; L_REQ = 1'b1;
    #1;
    chk("rst_c_gnt", C_GNT, 0);
    chk("rst_l_gnt", L_GNT, 0);
    chk("rst_m_en", M_EN, 0);
    chk("rst_c_rvalid", C_RVALID, 0);
    chk("rst_l_rvalid", L_RVALID, 0);
    chk("rst_l_done", L_DONE, 0);
`ifdef DMEM_ARB_STATS_EN
    chk("rst_stat_cstall", STAT_CSTALL, 0);
    chk("rst_stat_lbeats", STAT_LBEATS, 0);
`endif
    bursting = 0; b_left = 0; run = 0; wq.delete();
    c_exp.delete(); l_exp.delete();
    done_exp = 0; c_rd_prev = 0; l_rd_prev = 0;
    m_cstall = 0; m_lbeats = 0;
    repeat (hold) @(negedge CLK);
    RESET = 1'b0; C_REQ = 1'b0; L_REQ = 1'b0;
  endtask

  initial begin
    int c_cnt, l_cnt, mism;
    bit cp, cp_we;
    logic [7:0] cp_addr, cp_wdata;

    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[6] = 8'd128;
    ref_mem[6] = 8'd128;

    do_reset(3);

    // Core read of a known location.
    step(1, 0, 8'd6, 8'd0, 0, 0, 8'd0, 5'd0);
    idle_step();

    // 32-beat loader write into the search field.
    step(0, 0, 8'd0, 8'd0, 1, 1, 8'd128, 5'd31);
    drain();

    // Simultaneous core and loader requests from IDLE.
    step(1, 0, 8'd7, 8'd0, 1, 1, 8'd40, 5'd2);
    drain();

    // Core held throughout a 32-beat read burst.
    step(1, 0, 8'd9, 8'd0, 1, 0, 8'd128, 5'd31);
    c_cnt = 0; l_cnt = 0;
    for (int i = 0; i < 60 && bursting; i++) begin
      step(1, 0, 8'($urandom), 8'd0, 0, 0, 8'd0, 5'd0);
      c_cnt += int'(dut_c);
      l_cnt += int'(dut_l);
    end
    chk("starve_core_beats", c_cnt, 7);
    chk("starve_loader_beats", l_cnt, 32);
    drain();

    // Write burst wrapping past the top of memory.
    step(0, 0, 8'd0, 8'd0, 1, 1, 8'd254, 5'd3);
    drain();

    // Reset in the middle of a read burst.
    step(0, 0, 8'd0, 8'd0, 1, 0, 8'd60, 5'd31);
    for (int i = 0; i < 10; i++) idle_step();
    do_reset(2);
    idle_step();
    step(1, 0, 8'd6, 8'd0, 0, 0, 8'd0, 5'd0);
    idle_step();

    // Randomized mixed traffic.
    cp = 0; cp_we = 0; cp_addr = '0; cp_wdata = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!cp && ($urandom % 3 == 0)) begin
        cp = 1; cp_we = 1'($urandom); cp_addr = 8'($urandom); cp_wdata = 8'($urandom);
      end
      step(cp, cp_we, cp_addr, cp_wdata, ($urandom % 6 == 0), 1'($urandom),
           8'($urandom), 5'($urandom));
      if (last_exp_c) cp = 0;
    end
    drain();

    chk("c_queue_empty", c_exp.size(), 0);
    chk("l_queue_empty", l_exp.size(), 0);
    mism = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
    chk("mem_image", mism, 0);
`ifdef DMEM_ARB_STATS_EN
    chk("stat_cstall", STAT_CSTALL, m_cstall);
    chk("stat_lbeats", STAT_LBEATS, m_lbeats);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
